// File: rtl/luma_binarizer.sv
// Streaming RGB-to-luma converter with threshold binarisation; one frame of NUM_PIXEL pixels per start.
// Optional LUMA_ADAPT_TH_EN: the threshold is learned from the previous frame's mean luma.
module luma_binarizer #(
    parameter int DATA_W    = 10,
    parameter int FRAC_W    = 8,
    parameter int W_R       = 77,
    parameter int W_G       = 150,
    parameter int W_B       = 29,
    parameter int NUM_PIXEL = 480000,
    parameter int AVG_LOG2  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_threshold,
    output logic              o_read_request,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_luma,
    output logic              o_bw,
    output logic              o_last,
    output logic              o_done,
    output logic              o_busy
);

    localparam int SUM_W = DATA_W + FRAC_W + 2;
    localparam int CNT_W = $clog2(NUM_PIXEL + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXEL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_PIXEL);
    localparam logic [SUM_W-1:0] ROUND    = SUM_W'(1) << (FRAC_W - 1);
    localparam logic [SUM_W-1:0] LUMA_MAX = SUM_W'((1 << DATA_W) - 1);
    localparam logic [SUM_W-1:0] WR       = SUM_W'(W_R);
    localparam logic [SUM_W-1:0] WG       = SUM_W'(W_G);
    localparam logic [SUM_W-1:0] WB       = SUM_W'(W_B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] thr;
    logic [DATA_W-1:0] thr_start;
    logic              en;
    logic              accept;
    logic              take;
    logic              frame_end;

    logic [SUM_W-1:0]  prod_r;
    logic [SUM_W-1:0]  prod_g;
    logic [SUM_W-1:0]  prod_b;
    logic              s1_valid;
    logic              s1_last;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  shifted;
    logic [DATA_W-1:0] luma_sat;

    // Whole pipeline advances together; a stalled output freezes both stages.
    assign en        = !o_valid || i_ready;
    assign o_ready   = (state == RUN) && en;
    assign accept    = i_valid && o_ready;
    assign take      = o_valid && i_ready;
    assign frame_end = (state == DRAIN) && take && o_last;

    assign sum      = prod_r + prod_g + prod_b + ROUND;
    assign shifted  = sum >> FRAC_W;
    assign luma_sat = (shifted > LUMA_MAX) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            thr            <= '0;
            o_read_request <= 1'b0;
            o_done         <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_read_request <= 1'b0;
            o_done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state          <= RUN;
                        cnt            <= '0;
                        thr            <= thr_start;
                        o_read_request <= 1'b1;
                        o_busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Everything older than the last pixel has already left in order.
                    if (frame_end) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_luma   <= '0;
            o_bw     <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            s1_last  <= accept && (cnt == LAST_IDX);
            if (accept) begin
                prod_r <= SUM_W'(i_red) * WR;
                prod_g <= SUM_W'(i_green) * WG;
                prod_b <= SUM_W'(i_blue) * WB;
            end
            o_valid <= s1_valid;
            o_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                o_luma <= luma_sat;
                o_bw   <= (luma_sat <= thr);
            end
        end
    end

`ifdef LUMA_ADAPT_TH_EN
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int AVG_CW = AVG_LOG2 + 1;
    localparam logic [AVG_CW-1:0] AVG_N = AVG_CW'(1) << AVG_LOG2;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [AVG_CW-1:0] avg_cnt;
    logic [AVG_CW-1:0] avg_cnt_next;
    logic              acc_add;
    logic              learned;
    logic [DATA_W-1:0] thr_learned;

    // Next values include the pixel taken this cycle, so the final pixel counts at frame end.
    always_comb begin
        acc_add      = take && (avg_cnt != AVG_N);
        acc_next     = acc;
        avg_cnt_next = avg_cnt;
        if (acc_add) begin
            acc_next     = acc + ACC_W'(o_luma);
            avg_cnt_next = avg_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            avg_cnt     <= '0;
            learned     <= 1'b0;
            thr_learned <= '0;
        end else begin
            if ((state == IDLE) && i_start) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else begin
                acc     <= acc_next;
                avg_cnt <= avg_cnt_next;
            end
            if (frame_end && (avg_cnt_next == AVG_N)) begin
                thr_learned <= acc_next[ACC_W-1:AVG_LOG2];
                learned     <= 1'b1;
            end
        end
    end

    assign thr_start = learned ? thr_learned : i_threshold;
`else
    assign thr_start = i_threshold;
`endif

endmodule

// File: tb/tb_luma_binarizer.sv
// Directed bench for luma_binarizer: luma arithmetic, thresholding, backpressure, reset and start handling.
module tb_luma_binarizer;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic [9:0] i_threshold;
    logic       o_read_request;
    logic       i_valid;
    logic       o_ready;
    logic [9:0] i_red, i_green, i_blue;
    logic       o_valid;
    logic       i_ready;
    logic [9:0] o_luma;
    logic       o_bw, o_last, o_done, o_busy;

    logic       s_start;
    logic [9:0] s_threshold;
    logic       s_read_request;
    logic       s_ivalid;
    logic       s_oready;
    logic [9:0] s_red, s_green, s_blue;
    logic       s_ovalid;
    logic       s_iready;
    logic [9:0] s_luma;
    logic       s_bw, s_last, s_done, s_busy;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int rr_cnt = 0;
    int exp_done = 0;
    int exp_rr = 0;

    logic [9:0] pr [4];
    logic [9:0] pg [4];
    logic [9:0] pb [4];
    logic [9:0] el [4];
    logic       eb [4];

    luma_binarizer #(.NUM_PIXEL(4), .AVG_LOG2(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_threshold(i_threshold),
        .o_read_request(o_read_request), .i_valid(i_valid), .o_ready(o_ready),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_valid(o_valid), .i_ready(i_ready), .o_luma(o_luma), .o_bw(o_bw),
        .o_last(o_last), .o_done(o_done), .o_busy(o_busy)
    );

    luma_binarizer #(.W_R(256), .W_G(256), .W_B(256), .NUM_PIXEL(1)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_threshold(s_threshold),
        .o_read_request(s_read_request), .i_valid(s_ivalid), .o_ready(s_oready),
        .i_red(s_red), .i_green(s_green), .i_blue(s_blue),
        .o_valid(s_ovalid), .i_ready(s_iready), .o_luma(s_luma), .o_bw(s_bw),
        .o_last(s_last), .o_done(s_done), .o_busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_done) done_cnt++;
        if (o_read_request) rr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] thr);
        check("idle_ready", o_ready, 0);
        i_start     = 1'b1;
        i_threshold = thr;
        tick();
        i_start = 1'b0;
        exp_rr++;
        check("start_read_req", o_read_request, 1);
        check("start_busy", o_busy, 1);
    endtask

    task automatic set_gray(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
        pr = '{a, b, c, d};
        pg = '{a, b, c, d};
        pb = '{a, b, c, d};
        el = '{a, b, c, d};
    endtask

    // Drives one 4-pixel frame from pr/pg/pb and checks outputs against el/eb until o_done.
    task automatic run_frame(input bit bp, input bit poke);
        int   in_idx = 0;
        int   out_idx = 0;
        int   cyc = 0;
        int   first_acc = -1;
        int   first_val = -1;
        bit   stall_prev = 0;
        bit   done_seen = 0;
        bit   acc_now;
        bit   take_now;
        bit   last_take;
        logic [9:0] h_luma;
        logic h_bw;
        logic h_last;
        while (!done_seen && cyc < 200) begin
            check("read_req_pulse", o_read_request, (cyc == 0));
            check("busy_in_frame", o_busy, 1);
            i_ready = bp ? cyc[0] : 1'b1;
            i_valid = (in_idx < 4) && (!bp || ($urandom_range(0, 3) != 0));
            i_red   = (in_idx < 4) ? pr[in_idx] : 10'd0;
            i_green = (in_idx < 4) ? pg[in_idx] : 10'd0;
            i_blue  = (in_idx < 4) ? pb[in_idx] : 10'd0;
            i_start = poke && (cyc == 1);
            if (poke && cyc == 1) i_threshold = 10'd0;
            @(negedge clk);
            if (stall_prev) begin
                check("hold_luma", o_luma, h_luma);
                check("hold_bw", o_bw, h_bw);
                check("hold_last", o_last, h_last);
            end
            if (o_valid) begin
                if (first_val < 0) first_val = cyc;
                check("luma", o_luma, (out_idx < 4) ? el[out_idx] : 10'bx);
                check("bw", o_bw, (out_idx < 4) ? eb[out_idx] : 1'bx);
                check("last", o_last, (out_idx == 3));
            end
            if (o_valid && !i_ready) check("ready_in_stall", o_ready, 0);
            acc_now    = i_valid && o_ready;
            take_now   = o_valid && i_ready;
            last_take  = take_now && o_last;
            if (acc_now && first_acc < 0) first_acc = cyc;
            stall_prev = o_valid && !i_ready;
            h_luma     = o_luma;
            h_bw       = o_bw;
            h_last     = o_last;
            tick();
            if (acc_now) in_idx++;
            if (take_now) out_idx++;
            cyc++;
            check("done_timing", o_done, last_take);
            done_seen = o_done;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b1;
        exp_done++;
        check("frame_done", done_seen, 1);
        check("accepted", in_idx, 4);
        check("delivered", out_idx, 4);
        if (!bp) check("latency", first_val - first_acc, 2);
        tick();
        check("done_pulse_width", o_done, 0);
        check("busy_after_done", o_busy, 0);
        check("done_count", done_cnt, exp_done);
        check("read_req_count", rr_cnt, exp_rr);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 0; i_threshold = 0; i_valid = 0; i_ready = 1;
        i_red = 0; i_green = 0; i_blue = 0;
        s_start = 0; s_threshold = 10'd512; s_ivalid = 0; s_iready = 1;
        s_red = 0; s_green = 0; s_blue = 0;
        repeat (3) tick();

        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_luma", o_luma, 0);
        check("rst_bw", o_bw, 0);
        check("rst_last", o_last, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_read_req", o_read_request, 0);

        // start and reset together: reset wins
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_with_rst_busy", o_busy, 0);
        check("start_with_rst_rr", o_read_request, 0);
        rst = 1'b0;
        tick();

        // gray frame, no backpressure
        set_gray(10'd1023, 10'd0, 10'd512, 10'd513);
        eb = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_start(10'd512);
        run_frame(1'b0, 1'b0);

        // colour weights, threshold 200, ignored start mid-frame
        do_reset();
        pr = '{10'd512, 10'd0, 10'd0, 10'd1023};
        pg = '{10'd0, 10'd512, 10'd0, 10'd1023};
        pb = '{10'd0, 10'd0, 10'd1023, 10'd0};
        el = '{10'd154, 10'd300, 10'd116, 10'd907};
        eb = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_start(10'd200);
        run_frame(1'b0, 1'b1);

        // reset after two accepted pixels
        set_gray(10'd1023, 10'd0, 10'd512, 10'd513);
        eb = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_start(10'd512);
        i_valid = 1'b1;
        i_red = pr[0]; i_green = pg[0]; i_blue = pb[0];
        tick();
        i_red = pr[1]; i_green = pg[1]; i_blue = pb[1];
        tick();
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_ready", o_ready, 0);
        check("abort_done", o_done, 0);
        repeat (3) tick();
        check("abort_flushed", o_valid, 0);
        check("abort_no_done", done_cnt, exp_done);

        // clean frame with backpressure and input gaps
        do_start(10'd512);
        run_frame(1'b1, 1'b0);

        // saturation with unity-plus weights
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_ivalid = 1'b1;
        s_red = 10'd1023; s_green = 10'd1023; s_blue = 10'd1023;
        tick();
        s_ivalid = 1'b0;
        tick();
        check("sat_valid", s_ovalid, 1);
        check("sat_luma", s_luma, 1023);
        check("sat_bw", s_bw, 0);
        check("sat_last", s_last, 1);
        tick();
        check("sat_done", s_done, 1);

        // threshold learning over two frames
        do_reset();
        set_gray(10'd100, 10'd200, 10'd300, 10'd400);
        eb = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_start(10'd512);
        run_frame(1'b0, 1'b0);
        set_gray(10'd260, 10'd0, 10'd1023, 10'd250);
`ifdef LUMA_ADAPT_TH_EN
        eb = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        eb = '{1'b1, 1'b1, 1'b0, 1'b1};
`endif
        do_start(10'd512);
        run_frame(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/luma_binarizer.md
# luma_binarizer

Parametrised streaming RGB-to-luma converter and binariser for the camera pipeline. It sits between the SDRAM pixel reader and the downstream image-processing stages. It runs one frame of NUM_PIXEL pixels per start and supports per-channel weights, full valid/ready backpressure and a runtime threshold. Optionally, the threshold adapts from the previous frame's mean luma.

## Interface
- DATA_W, 10: bits per colour channel and luma output
- FRAC_W, 8: fractional bits of the channel weights
- W_R, 77: red weight (value / 2^FRAC_W)
- W_G, 150: green weight
- W_B, 29: blue weight
- NUM_PIXEL, 480000: pixels per frame
- AVG_LOG2, 10: log2 of the pixel count averaged for the adaptive threshold (used only with LUMA_ADAPT_TH_EN)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start one frame; honoured only in IDLE
- i_threshold  in  DATA_W  static threshold, sampled on accepted i_start
- o_read_request  out  1  one-cycle pulse on the first RUN cycle, to the SDRAM reader
- i_valid  in  1  input pixel valid
- o_ready  out  1  block accepts the pixel this cycle
- i_red, i_green, i_blue  in  DATA_W each  input pixel
- o_valid  out  1  output pixel valid
- i_ready  in  1  downstream accepts the output
- o_luma  out  DATA_W  weighted luma
- o_bw  out  1  1 when o_luma <= active threshold, else 0
- o_last  out  1  qualifies the final output pixel of the frame
- o_done  out  1  one-cycle pulse when the frame has fully drained
- o_busy  out  1  high in RUN or DRAIN

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on i_start. The accepted-input counter clears, the threshold is latched and o_read_request pulses.
- RUN: a pixel is accepted when i_valid && o_ready. After the NUM_PIXEL-th acceptance the FSM goes to DRAIN and o_ready drops.
- DRAIN: waits until the pipeline is empty and the last output has been taken (o_valid && o_last && i_ready). It then pulses o_done and returns to IDLE.
- i_start outside IDLE is ignored.
- Luma arithmetic:
  - Computed as (W_R·r + W_G·g + W_B·b + 2^(FRAC_W-1)) >> FRAC_W, which is round-half-up.
  - Products and sum are unsigned and at least DATA_W+FRAC_W+2 bits wide.
  - The result saturates to 2^DATA_W−1 when the weights sum to more than 2^FRAC_W.
- o_bw compares unsigned; a tie gives 1.
- Counter width is $clog2(NUM_PIXEL+1). The counter never wraps: it stops at NUM_PIXEL.
- o_luma, o_bw and o_last are stable while o_valid && !i_ready.

## Timing
- Two-stage pipeline: stage 1 registers the three products; stage 2 registers sum/round/saturate plus the compare.
- Latency is 2 cycles from input acceptance to o_valid when there is no stall.
- Global pipeline enable: en = !o_valid || i_ready. o_ready = (state==RUN) && en.
- Throughput is 1 pixel/cycle without backpressure.
- Reset values:
  - state IDLE; all valid bits 0.
  - o_ready, o_valid, o_bw, o_last, o_done, o_busy, o_read_request = 0.
  - o_luma = 0; counters = 0.
- Reset mid-frame aborts the frame immediately: no o_done, and pipeline contents are discarded.
- Start and reset in the same cycle: reset wins.

## Configuration
- LUMA_ADAPT_TH_EN defined:
  - During each frame, the luma of the first 2^AVG_LOG2 output pixels is accumulated in an (DATA_W+AVG_LOG2)-bit accumulator.
  - At o_done, the next-frame threshold becomes acc >> AVG_LOG2 and a "learned" flag is set.
  - Later starts use the learned value and ignore i_threshold.
  - If the frame is shorter than 2^AVG_LOG2 pixels, the threshold is not updated.
  - Reset clears the accumulator and the flag.
- Undefined: the threshold is always i_threshold, latched at start; no accumulator logic exists.

## Test plan
- Default params, NUM_PIXEL=4, i_threshold=512; feed gray pixels r=g=b=1023, 0, 512, 513 back-to-back with i_ready=1 → o_luma 1023, 0, 512, 513; o_bw 0, 1, 1, 0; first o_valid 2 cycles after first accept; o_last on 4th; o_done 1 cycle later.
- Input (512,0,0) → o_luma=154. W_R=W_G=W_B=256 with (1023,1023,1023) → o_luma=1023 (saturated).
- Backpressure: i_ready toggled 0/1 every cycle plus random i_valid gaps → all 4 outputs in order with no drop or duplicate, held stable while stalled, o_ready low whenever o_valid && !i_ready.
- Reset asserted after 2 accepted pixels → next cycle state IDLE, o_valid=0, no o_done; new i_start runs a full clean frame.
- i_start pulsed during RUN → ignored; exactly one o_done per frame; o_read_request pulses once per accepted start.
- LUMA_ADAPT_TH_EN, AVG_LOG2=2: frame 1 grays 100, 200, 300, 400 → learned threshold 250; frame 2 pixel gray 260 → o_bw=0 (without macro, i_threshold=512 → o_bw=1).
